// File: rtl/rle_expander_pkg.sv
// rle_expander_pkg: shared codeword width and decode FSM state encoding.
package rle_expander_pkg;
    localparam int CW_W = 8;
    typedef enum logic [1:0] {S_CNT = 2'b00, S_SYM = 2'b01, S_EMIT = 2'b10} state_t;
endpackage

// File: rtl/codeword_fifo.sv
// codeword_fifo: codeword buffer with occupancy count; head readable combinationally.
module codeword_fifo
    import rle_expander_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW = 3
) (
    input  logic            tclk,
    input  logic            rst,
    input  logic            clr,
    input  logic            push,
    input  logic [CW_W-1:0] din,
    input  logic            pop,
    output logic [CW_W-1:0] dout,
    output logic            empty,
    output logic            full,
    output logic [AW:0]     level
);
    logic [CW_W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic wr, rd;
    assign empty = level == '0;
    assign full = level == (AW+1)'(DEPTH);
    assign wr = push & ~full;
    assign rd = pop & ~empty;
    assign dout = mem[rp];
    // Full/empty derive from level, so pointers can simply wrap.
    always_ff @(posedge tclk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            level <= '0;
        end else if (clr) begin
            wp <= '0;
            rp <= '0;
            level <= '0;
        end else begin
            wp <= wp + AW'(wr);
            rp <= rp + AW'(rd);
            level <= level + (AW+1)'(wr) - (AW+1)'(rd);
        end
    end
    always_ff @(posedge tclk) begin
        if (wr && !clr) mem[wp] <= din;
    end
endmodule

// File: rtl/rle_expander.sv
// rle_expander: buffers {count, symbol} codewords from the framer and
// replays each symbol count times on a valid/ready byte port.
module rle_expander
    import rle_expander_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW = 3
) (
    input  logic            tclk,
    input  logic            rst,
    input  logic            frameClr,
    input  logic [CW_W-1:0] codeWord,
    input  logic            valid,
    output logic            stackFull,
    output logic [CW_W-1:0] dataOut,
    output logic            outValid,
    input  logic            outReady,
    output logic            busy,
    output logic            overflow
);
    logic valid_d, push, wr, pop, empty, full;
    logic [CW_W-1:0] head, cnt, cnt_nx, sym, sym_nx;
    logic [AW:0] level, level_nx;
    state_t state, state_nx;
    // A stalled framer holds valid high; only its rising edge is a new word.
    assign push = valid & ~valid_d & ~frameClr;
    assign wr = push & ~full;
    assign level_nx = frameClr ? '0 : level + (AW+1)'(wr) - (AW+1)'(pop);
    assign outValid = state == S_EMIT;
    assign dataOut = sym;
    assign busy = ~empty | (state != S_CNT);
    codeword_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
        .tclk(tclk),
        .rst(rst),
        .clr(frameClr),
        .push(push),
        .din(codeWord),
        .pop(pop),
        .dout(head),
        .empty(empty),
        .full(full),
        .level(level)
    );
    always_ff @(posedge tclk or posedge rst) begin
        if (rst) begin
            valid_d <= 1'b0;
            stackFull <= 1'b0;
            overflow <= 1'b0;
            state <= S_CNT;
            cnt <= '0;
            sym <= '0;
        end else begin
            valid_d <= valid;
            stackFull <= level_nx >= (AW+1)'(DEPTH-2);
            overflow <= frameClr ? 1'b0 : overflow | (push & full);
            state <= state_nx;
            cnt <= cnt_nx;
            sym <= sym_nx;
        end
    end
    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        sym_nx = sym;
        pop = 1'b0;
        case (state)
            S_CNT: if (!empty) begin
                cnt_nx = head;
                pop = 1'b1;
                state_nx = S_SYM;
            end
            S_SYM: if (!empty) begin
                sym_nx = head;
                pop = 1'b1;
                state_nx = (cnt == '0) ? S_CNT : S_EMIT;
            end
            S_EMIT: if (outReady) begin
                cnt_nx = cnt - CW_W'(1);
                state_nx = (cnt == CW_W'(1)) ? S_CNT : S_EMIT;
            end
            default: state_nx = S_CNT;
        endcase
        if (frameClr) begin
            state_nx = S_CNT;
            cnt_nx = '0;
            sym_nx = '0;
            pop = 1'b0;
        end
    end
endmodule
